capture_emit_seq: RTL and testbench

//  Parametrised capture/emit sequencer: collects BURST input samples of WIDTH bits, then replays

---
 rtl/capture_emit_seq.sv | 127 ++++++++++++
 tb/tb_capture_emit_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_emit_seq.sv
// Capture/emit sequencer: gathers BURST samples, then replays them (FIFO or LIFO) on a
// valid/ready output. Define CES_OVERRUN_CNT_EN to add the saturating overrun_cnt port.
module capture_emit_seq #(
  parameter int WIDTH   = 3,
  parameter int BURST   = 1,
  parameter bit REVERSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef CES_OVERRUN_CNT_EN
  output logic [7:0]       overrun_cnt,
`endif
  output logic             dbg_state_o
);

  // Handshakes: a capture happens on in_valid & in_ready, an emit on out_valid & out_ready;
  // out_valid/out_data stay stable until the emit handshake completes.

  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BURST - 1);
  localparam logic [IW-1:0] RD_START = REVERSE ? LAST_IDX : '0;
  localparam logic [IW-1:0] RD_END   = REVERSE ? '0 : LAST_IDX;

  typedef enum logic {
    S_CAPTURE = 1'b0,
    S_EMIT    = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic [IW-1:0]    rd_next;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] mem_q [BURST];

  logic cap_fire, emit_fire, cap_last, emit_last;

  assign cap_fire  = (state_q == S_CAPTURE) && in_valid;
  assign emit_fire = (state_q == S_EMIT) && out_ready;
  assign cap_last  = cap_fire && (wr_idx_q == LAST_IDX);
  assign emit_last = emit_fire && (rd_idx_q == RD_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_CAPTURE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CAPTURE: if (cap_last)  state_d = S_EMIT;
      S_EMIT:    if (emit_last) state_d = S_CAPTURE;
      default:   state_d = S_CAPTURE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_CAPTURE);
    out_valid = (state_q == S_EMIT);
  end

  assign out_data    = out_data_q;
  assign dbg_state_o = state_q;

  // The first replayed entry may be the one written on the same edge, so bypass it from in_data.
  always_comb begin
    rd_next    = REVERSE ? (rd_idx_q - IW'(1)) : (rd_idx_q + IW'(1));
    first_word = (RD_START == LAST_IDX) ? in_data : mem_q[RD_START];
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    out_data_d = out_data_q;
    if (cap_fire) begin
      wr_idx_d = cap_last ? '0 : (wr_idx_q + IW'(1));
      if (cap_last) out_data_d = first_word;
    end
    if (emit_fire) begin
      if (emit_last) begin
        rd_idx_d   = RD_START;
        out_data_d = '0;
      end else begin
        rd_idx_d   = rd_next;
        out_data_d = mem_q[rd_next];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q   <= '0;
      rd_idx_q   <= RD_START;
      out_data_q <= '0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      out_data_q <= out_data_d;
    end
  end

  // Sample storage is never read before written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (cap_fire) mem_q[wr_idx_q] <= in_data;
  end

`ifdef CES_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if ((state_q == S_EMIT) && in_valid && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovr_q <= 8'd0;
    else     ovr_q <= ovr_d;
  end

  assign overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_capture_emit_seq.sv
// Bench for capture_emit_seq: three instances (BURST=1, BURST=4 FIFO, BURST=4 LIFO) share
// stimulus and are scored against a queue-based burst model.
module tb_capture_emit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       ir0, ir1, ir2, ov0, ov1, ov2, st0, st1, st2;
  logic [2:0] od0;
  logic [7:0] od1, od2;
`ifdef CES_OVERRUN_CNT_EN
  logic [7:0] oc0, oc1, oc2;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  capture_emit_seq #(.WIDTH(3), .BURST(1), .REVERSE(1'b0)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[2:0]),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
`ifdef CES_OVERRUN_CNT_EN
    .overrun_cnt(oc0),
`endif
    .dbg_state_o(st0));

  capture_emit_seq #(.WIDTH(8), .BURST(4), .REVERSE(1'b0)) u_f4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
`ifdef CES_OVERRUN_CNT_EN
    .overrun_cnt(oc1),
`endif
    .dbg_state_o(st1));

  capture_emit_seq #(.WIDTH(8), .BURST(4), .REVERSE(1'b1)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
`ifdef CES_OVERRUN_CNT_EN
    .overrun_cnt(oc2),
`endif
    .dbg_state_o(st2));

  // Reference model: per instance, a phase flag, the samples gathered so far, and the
  // expected replay order queued once a burst completes.
  int         brst [3] = '{1, 4, 4};
  bit         rev  [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] mask [3] = '{8'h07, 8'hFF, 8'hFF};
  bit         m_emit [3];
  int         m_cnt  [3];
  int         m_ovr  [3];
  logic [7:0] m_cap  [3][4];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void exp_push(input int k, input logic [7:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int exp_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [7:0] exp_front(input int k);
    if (exp_size(k) == 0) return 8'h00;
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic void exp_pop(input int k);
    if (exp_size(k) == 0) return;
    case (k)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_emit[k] = 1'b0;
      m_cnt[k]  = 0;
      m_ovr[k]  = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endfunction

  function automatic void model_step(input bit iv, input logic [7:0] id, input bit ordy);
    for (int k = 0; k < 3; k++) begin
      if (!m_emit[k]) begin
        if (iv) begin
          m_cap[k][m_cnt[k]] = id & mask[k];
          m_cnt[k]++;
          if (m_cnt[k] == brst[k]) begin
            for (int j = 0; j < brst[k]; j++)
              exp_push(k, rev[k] ? m_cap[k][brst[k]-1-j] : m_cap[k][j]);
            m_cnt[k]  = 0;
            m_emit[k] = 1'b1;
          end
        end
      end else begin
        if (iv && m_ovr[k] < 255) m_ovr[k]++;
        if (ordy) begin
          exp_pop(k);
          if (exp_size(k) == 0) m_emit[k] = 1'b0;
        end
      end
    end
  endfunction

  task automatic check_outputs(input string where);
    logic       a_ir, a_ov;
    logic [7:0] a_od, a_oc;
    for (int k = 0; k < 3; k++) begin
      a_oc = 8'h00;
      case (k)
        0: begin a_ir = ir0; a_ov = ov0; a_od = {5'd0, od0};
`ifdef CES_OVERRUN_CNT_EN
             a_oc = oc0;
`endif
           end
        1: begin a_ir = ir1; a_ov = ov1; a_od = od1;
`ifdef CES_OVERRUN_CNT_EN
             a_oc = oc1;
`endif
           end
        default: begin a_ir = ir2; a_ov = ov2; a_od = od2;
`ifdef CES_OVERRUN_CNT_EN
             a_oc = oc2;
`endif
           end
      endcase
      chk($sformatf("%s c%0d u%0d in_ready", where, cyc, k), 32'(a_ir), 32'(!m_emit[k]));
      chk($sformatf("%s c%0d u%0d out_valid", where, cyc, k), 32'(a_ov), 32'(m_emit[k]));
      chk($sformatf("%s c%0d u%0d out_data", where, cyc, k), 32'(a_od),
          32'(m_emit[k] ? exp_front(k) : 8'h00));
`ifdef CES_OVERRUN_CNT_EN
      chk($sformatf("%s c%0d u%0d overrun_cnt", where, cyc, k), 32'(a_oc), 32'(m_ovr[k]));
`else
      if (a_oc != 8'h00) chk("no_overrun_port", 32'(a_oc), 32'h0);
`endif
    end
  endtask

  // Called just after a falling edge; applies inputs for one rising edge, then checks.
  task automatic drive_cycle(input bit iv, input logic [7:0] id, input bit ordy, input string where);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    model_step(iv, id, ordy);
    cyc++;
    @(negedge clk);
    #1;
    check_outputs(where);
  endtask

  // Reset asserted and released between clock edges.
  task automatic reset_pulse();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #1 rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("reset");

    // Free-flowing capture/emit with incrementing data (5, 6, 7, ...).
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 8'(5 + i), 1'b1, "flow");

    // Consumer stalled while the sampler keeps presenting data.
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, "stall");
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, 8'h00, 1'b1, "drain");

    // Reset after two captures into the 4-deep instances.
    reset_pulse();
    drive_cycle(1'b1, 8'hA1, 1'b1, "mid");
    drive_cycle(1'b1, 8'hA2, 1'b1, "mid");
    reset_pulse();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b1, "post_rst");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0, "rand");
      if ($urandom_range(0, 149) == 0) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
